// File: rtl/mem_cmdq_pkg.sv
// Shared types for the memory command queue: command record, FSM states and opcode constants.
// The address width widens to 5 bits when CMDQ_ADDR_CHK_EN is defined so out-of-range addresses are expressible.
package mem_cmdq_pkg;

  localparam int CMDQ_WIDTH = 8;
  localparam int CMDQ_DEPTH = 16;
`ifdef CMDQ_ADDR_CHK_EN
  localparam int CMDQ_ADDR_WIDTH = 5;
`else
  localparam int CMDQ_ADDR_WIDTH = 4;
`endif

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef struct packed {
    logic                       wr_rd;
    logic [CMDQ_ADDR_WIDTH-1:0] addr;
    logic [CMDQ_WIDTH-1:0]      wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } cmdq_state_e;

  function automatic logic addr_in_range(input logic [CMDQ_ADDR_WIDTH-1:0] a,
                                         input int unsigned depth);
    return 32'(a) < depth;
  endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
// The head entry is presented combinationally so a pop and its data land in the same cycle.
module mem_cmd_fifo
  import mem_cmdq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  cmd_t                          push_cmd_i,
  input  logic                          pop_i,
  output cmd_t                          head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q;
  logic [PW:0]   rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign fill_o  = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_cmd_i;
  end

endmodule

// File: rtl/mem_cmd_queue.sv
// Command queue in front of the memory: buffers producer commands, issues them one at a time, returns read data.
// Define CMDQ_ADDR_CHK_EN to reject commands whose address is >= DEPTH (bad reads answer with r_err=1).
module mem_cmd_queue
  import mem_cmdq_pkg::*;
#(
  parameter int WIDTH      = CMDQ_WIDTH,
  parameter int DEPTH      = CMDQ_DEPTH,
  parameter int ADDR_WIDTH = CMDQ_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_wr_rd,
  input  logic [ADDR_WIDTH-1:0]         s_addr,
  input  logic [WIDTH-1:0]              s_wdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_wr_rd,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [WIDTH-1:0]              m_wdata,
  input  logic [WIDTH-1:0]              m_rdata,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [WIDTH-1:0]              r_data,
  output logic                          r_err,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

`ifdef CMDQ_ADDR_CHK_EN
  localparam logic ADDR_CHK = 1'b1;
`else
  localparam logic ADDR_CHK = 1'b0;
`endif

  // Valid/ready: a transfer happens on every rising edge where valid && ready; a source holds
  // valid and its payload stable until that edge, and ready may depend on nothing of the source.
  cmdq_state_e             state_q;
  cmd_t                    s_cmd;
  cmd_t                    head;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    head_bad;

  logic                    m_valid_q;
  logic                    m_wr_rd_q;
  logic [ADDR_WIDTH-1:0]   m_addr_q;
  logic [WIDTH-1:0]        m_wdata_q;
  logic                    r_valid_q;
  logic [WIDTH-1:0]        r_data_q;
  logic                    r_err_q;

  // No pop-dependent accept: a full queue refuses even if the head leaves this cycle.
  assign s_ready = !full && !res;
  assign push    = s_valid && s_ready;
  assign s_cmd   = '{wr_rd: s_wr_rd, addr: s_addr, wdata: s_wdata};
  assign pop     = (state_q == IDLE) && !empty;

  // Folds to constant 0 when the address check is compiled out, so r_err stays tied low.
  assign head_bad = ADDR_CHK && !addr_in_range(head.addr, DEPTH);

  mem_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (res),
    .push_i     (push),
    .push_cmd_i (s_cmd),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .fill_o     (fill)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_wr_rd_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            if (head_bad) begin
              // Bad writes vanish; bad reads still owe the producer a response.
              if (head.wr_rd == RD) begin
                r_valid_q <= 1'b1;
                r_data_q  <= '0;
                r_err_q   <= 1'b1;
                state_q   <= RESP;
              end
            end else begin
              m_valid_q <= 1'b1;
              m_wr_rd_q <= head.wr_rd;
              m_addr_q  <= head.addr;
              m_wdata_q <= head.wdata;
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (m_wr_rd_q == RD) begin
              r_valid_q <= 1'b1;
              r_data_q  <= m_rdata;
              r_err_q   <= 1'b0;
              state_q   <= RESP;
            end else begin
              state_q   <= IDLE;
            end
          end
        end
        RESP: begin
          // Blocking here keeps read responses in command order.
          if (r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_wr_rd = m_wr_rd_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign r_err   = r_err_q;

endmodule
